// File: rtl/opo_package.sv
// Shared types and constants for the LIA output path: word width, EMA low-pass
// sequencer states and a generic signed saturation helper.
package opo_package;

   localparam int word_width      = 16;
   localparam int lpf_shift_width = 5;

   typedef enum logic [1:0] {
      LPF_IDLE = 2'd0,
      LPF_RUN  = 2'd1,
      LPF_DONE = 2'd2
   } lpf_seq_state_t;

   // Clamp a 64-bit signed value to the range of a w-bit signed word.
   function automatic logic signed [63:0] lpf_saturate(input logic signed [63:0] v,
                                                       input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] r;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         r = hi;
      end else if (v < lo) begin
         r = lo;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/lpf_ema_update.sv
// One EMA step y + ((x - y) >>> k), saturated to the state width; a disabled
// stage simply adopts its input so re-enabling it is bumpless.
module lpf_ema_update
   import opo_package::*;
#(
   parameter int state_width = 25,
   parameter int shift_width = 5
) (
   input  logic [state_width-1:0] y_i,
   input  logic [state_width-1:0] x_i,
   input  logic [shift_width-1:0] k_i,
   input  logic                   en_i,
   output logic [state_width-1:0] y_next_o
);

   logic signed [state_width:0] diff;
   logic signed [state_width:0] step;
   logic signed [63:0]          sum;
   logic signed [63:0]          sum_sat;
   logic                        unused_sat_hi;

   always_comb begin
      diff    = $signed({x_i[state_width-1], x_i}) - $signed({y_i[state_width-1], y_i});
      step    = diff >>> k_i;
      sum     = {{(63 - state_width){step[state_width]}}, step}
              + {{(64 - state_width){y_i[state_width-1]}}, y_i};
      sum_sat = lpf_saturate(sum, state_width);
      y_next_o = en_i ? sum_sat[state_width-1:0] : x_i;
   end

   assign unused_sat_hi = ^sum_sat[63:state_width];

endmodule

// File: rtl/cascade_ema_low_pass_filter.sv
// Cascade of first-order EMA stages sharing one update datapath, sequenced one
// stage per cycle. Define LPF_ROUND_OUTPUT_EN for round-half-up output scaling.
module cascade_ema_low_pass_filter
   import opo_package::*;
#(
   parameter int num_stages  = 4,
   parameter int guard_bits  = 8,
   parameter int shift_width = lpf_shift_width
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [num_stages-1:0]             stage_enable,
   input  logic [num_stages*shift_width-1:0] stage_shift,
   input  logic                              filter_clear,
   input  logic [word_width-1:0]             sample_in,
   input  logic                              sample_in_valid,
   output logic                              sample_in_ready,
   output logic [word_width-1:0]             sample_out,
   output logic                              sample_out_valid,
   output logic                              overrun
);

   localparam int SW   = word_width + guard_bits + 1;
   localparam int IdxW = (num_stages > 1) ? $clog2(num_stages) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(num_stages - 1);

   generate
      if (num_stages < 1 || num_stages > 16) begin : g_bad_cfg
         $error("num_stages must be in the range 1..16");
      end
   endgenerate

   lpf_seq_state_t                    state_q, state_d;
   logic [IdxW-1:0]                   idx_q, idx_d;
   logic [word_width-1:0]             sample_q, sample_d;
   logic [num_stages-1:0]             en_snap_q, en_snap_d;
   logic [num_stages*shift_width-1:0] shift_snap_q, shift_snap_d;
   logic [word_width-1:0]             out_q, out_d;
   logic                              out_valid_q, out_valid_d;
   logic                              overrun_q, overrun_d;
   logic signed [SW-1:0]              y_q [num_stages];

   logic [shift_width-1:0]            shift_field [num_stages];
   logic [IdxW-1:0]                   idx_prev;
   logic signed [SW-1:0]              x0;
   logic signed [SW-1:0]              stage_x;
   logic [SW-1:0]                     y_upd;
   logic signed [SW-1:0]              y_last;
   logic signed [63:0]                y_ext;
   logic signed [63:0]                y_scaled;
   logic signed [63:0]                y_sat;
   logic [word_width-1:0]             out_sat;
   logic                              unused_out_hi;

   genvar gi;
   generate
      for (gi = 0; gi < num_stages; gi++) begin : g_shift_field
         assign shift_field[gi] = shift_snap_q[gi*shift_width +: shift_width];
      end
   endgenerate

   // Stage 0 sees the latched sample in state scaling; later stages see the
   // value their predecessor wrote on the previous cycle.
   always_comb begin
      x0       = {{(SW - word_width){sample_q[word_width-1]}}, sample_q} <<< guard_bits;
      idx_prev = idx_q - 1'b1;
      stage_x  = (idx_q == '0) ? x0 : y_q[idx_prev];
   end

   lpf_ema_update #(
      .state_width (SW),
      .shift_width (shift_width)
   ) u_update (
      .y_i      (y_q[idx_q]),
      .x_i      (stage_x),
      .k_i      (shift_field[idx_q]),
      .en_i     (en_snap_q[idx_q]),
      .y_next_o (y_upd)
   );

`ifdef LPF_ROUND_OUTPUT_EN
   localparam logic signed [63:0] RoundBias =
      (guard_bits > 0) ? (64'sd1 <<< (guard_bits - 1)) : 64'sd0;
`endif

   always_comb begin
      y_last = y_q[num_stages-1];
      y_ext  = {{(64 - SW){y_last[SW-1]}}, y_last};
`ifdef LPF_ROUND_OUTPUT_EN
      y_scaled = (y_ext + RoundBias) >>> guard_bits;
`else
      y_scaled = y_ext >>> guard_bits;
`endif
      y_sat   = lpf_saturate(y_scaled, word_width);
      out_sat = y_sat[word_width-1:0];
   end

   assign unused_out_hi = ^y_sat[63:word_width];

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      sample_d     = sample_q;
      en_snap_d    = en_snap_q;
      shift_snap_d = shift_snap_q;
      out_d        = out_q;
      out_valid_d  = 1'b0;
      overrun_d    = overrun_q;

      if (sample_in_valid && state_q != LPF_IDLE) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         LPF_IDLE: begin
            if (sample_in_valid) begin
               sample_d     = sample_in;
               en_snap_d    = stage_enable;
               shift_snap_d = stage_shift;
               idx_d        = '0;
               state_d      = LPF_RUN;
            end
         end
         LPF_RUN: begin
            if (idx_q == LastIdx) begin
               state_d = LPF_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         LPF_DONE: begin
            out_d       = out_sat;
            out_valid_d = 1'b1;
            state_d     = LPF_IDLE;
         end
         default: state_d = LPF_IDLE;
      endcase

      // Clear outranks acceptance, sequencing and the output pulse.
      if (filter_clear) begin
         state_d     = LPF_IDLE;
         idx_d       = '0;
         out_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= LPF_IDLE;
         idx_q        <= '0;
         sample_q     <= '0;
         en_snap_q    <= '0;
         shift_snap_q <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         sample_q     <= sample_d;
         en_snap_q    <= en_snap_d;
         shift_snap_q <= shift_snap_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < num_stages; i++) begin
            y_q[i] <= '0;
         end
      end else if (filter_clear) begin
         for (int i = 0; i < num_stages; i++) begin
            y_q[i] <= '0;
         end
      end else if (state_q == LPF_RUN) begin
         y_q[idx_q] <= y_upd;
      end
   end

   assign sample_in_ready  = (state_q == LPF_IDLE);
   assign sample_out       = out_q;
   assign sample_out_valid = out_valid_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_cascade_ema_low_pass_filter.sv
// Self-checking bench: table of accepted samples with expected outputs fed
// through a scoreboard, plus hand sequences for overrun, clear and reset.
module tb_cascade_ema_low_pass_filter;
   import opo_package::*;

   localparam int NS  = 4;
   localparam int GB  = 8;
   localparam int SHW = 5;
   localparam int WW  = word_width;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NS-1:0]         stage_enable = '0;
   logic [NS*SHW-1:0]     stage_shift = '0;
   logic                  filter_clear = 1'b0;
   logic [WW-1:0]         sample_in = '0;
   logic                  sample_in_valid = 1'b0;
   logic                  sample_in_ready;
   logic [WW-1:0]         sample_out;
   logic                  sample_out_valid;
   logic                  overrun;

   cascade_ema_low_pass_filter #(
      .num_stages  (NS),
      .guard_bits  (GB),
      .shift_width (SHW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stage_enable     (stage_enable),
      .stage_shift      (stage_shift),
      .filter_clear     (filter_clear),
      .sample_in        (sample_in),
      .sample_in_valid  (sample_in_valid),
      .sample_in_ready  (sample_in_ready),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .overrun          (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NS-1:0]            en;
      logic [NS*SHW-1:0]        sh;
      logic signed [WW-1:0]     din;
      logic signed [WW-1:0]     exp_trunc;
      logic signed [WW-1:0]     exp_round;
   } vec_t;

   typedef struct {
      logic signed [WW-1:0] out;
      int                   acc;
   } sb_t;

   vec_t vecs [10];
   sb_t  sb_q [$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [WW-1:0] pick(input logic signed [WW-1:0] t,
                                                 input logic signed [WW-1:0] r);
`ifdef LPF_ROUND_OUTPUT_EN
      return r;
`else
      return t;
`endif
   endfunction

   // Output monitor: every pulse must match the oldest pending expectation.
   always @(posedge clk) begin
      sb_t e;
      #1;
      if (sample_out_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("sample_out", $signed(sample_out), e.out);
            check("latency", cyc - e.acc, NS + 1);
            $display("out %0d expected %0d at cycle %0d", $signed(sample_out), e.out, cyc);
         end
      end
   end

   task automatic send(input logic signed [WW-1:0] d, input logic signed [WW-1:0] exp_o);
      int w;
      w = 0;
      @(negedge clk);
      while (!sample_in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!sample_in_ready) check("ready_timeout", 0, 1);
      sample_in       = d;
      sample_in_valid = 1'b1;
      @(posedge clk);
      #1;
      sb_q.push_back('{exp_o, cyc});
      $display("in %0d at cycle %0d", d, cyc);
      @(negedge clk);
      sample_in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain_pending", sb_q.size(), 0);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      filter_clear = 1'b1;
      @(negedge clk);
      filter_clear = 1'b0;
   endtask

   initial begin
      int lo;

      vecs[0] = '{4'b0001, 20'h00001, 16'sd1000,   16'sd500,    16'sd500};
      vecs[1] = '{4'b0001, 20'h00001, 16'sd1000,   16'sd750,    16'sd750};
      vecs[2] = '{4'b0001, 20'h00001, 16'sd1000,   16'sd875,    16'sd875};
      vecs[3] = '{4'b0000, 20'h00000, -16'sd1234,  -16'sd1234,  -16'sd1234};
      vecs[4] = '{4'b0000, 20'h00000, 16'sd77,     16'sd77,     16'sd77};
      vecs[5] = '{4'b1111, 20'h00000, -16'sd32768, -16'sd32768, -16'sd32768};
      vecs[6] = '{4'b1111, 20'h00000, 16'sd32767,  16'sd32767,  16'sd32767};
      vecs[7] = '{4'b1111, 20'hFFFFF, -16'sd32768, 16'sd32766,  16'sd32767};
      vecs[8] = '{4'b1111, 20'hFFFFF, 16'sd32767,  16'sd32766,  16'sd32767};
      vecs[9] = '{4'b1111, 20'h00000, -16'sd32768, -16'sd32768, -16'sd32768};

      repeat (3) @(posedge clk);
      #1;
      check("reset_sample_out", sample_out, 0);
      check("reset_valid", sample_out_valid, 0);
      check("reset_ready", sample_in_ready, 1);
      check("reset_overrun", overrun, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         stage_enable = vecs[i].en;
         stage_shift  = vecs[i].sh;
         send(vecs[i].din, pick(vecs[i].exp_trunc, vecs[i].exp_round));
      end
      drain();
      check("overrun_after_table", overrun, 0);

      // Back-to-back valid: second sample dropped, ready low for NS+1 cycles.
      stage_enable = 4'b0000;
      stage_shift  = '0;
      @(negedge clk);
      sample_in       = 16'sd500;
      sample_in_valid = 1'b1;
      @(posedge clk);
      #1;
      sb_q.push_back('{16'sd500, cyc});
      lo = sample_in_ready ? 0 : 1;
      @(posedge clk);
      #1;
      if (!sample_in_ready) lo++;
      @(negedge clk);
      sample_in_valid = 1'b0;
      for (int i = 0; i < 20 && !sample_in_ready; i++) begin
         @(posedge clk);
         #1;
         if (!sample_in_ready) lo++;
      end
      check("ready_low_cycles", lo, NS + 1);
      check("overrun_set", overrun, 1);
      drain();
      check("overrun_sticky", overrun, 1);
      check("out_before_clear", $signed(sample_out), 500);
      pulse_clear();
      #1;
      check("overrun_cleared", overrun, 0);
      check("out_holds_on_clear", $signed(sample_out), 500);
      stage_enable = 4'b0001;
      stage_shift  = 20'h00001;
      send(16'sd1000, 16'sd500);
      drain();

      // Clear mid-sequence: no output pulse, state zeroed.
      @(negedge clk);
      sample_in       = 16'sd1000;
      sample_in_valid = 1'b1;
      @(negedge clk);
      sample_in_valid = 1'b0;
      filter_clear    = 1'b1;
      @(negedge clk);
      filter_clear    = 1'b0;
      check("ready_after_clear", sample_in_ready, 1);
      repeat (8) @(posedge clk);
      send(16'sd1000, 16'sd500);
      drain();

      // Reset during stage idx=2.
      @(negedge clk);
      sample_in       = 16'sd1000;
      sample_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sample_in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrun_reset_out", sample_out, 0);
      check("midrun_reset_ready", sample_in_ready, 1);
      check("midrun_reset_valid", sample_out_valid, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(posedge clk);
      send(16'sd1000, 16'sd500);
      drain();

      // Output rounding: y = 192 with 8 guard bits.
      pulse_clear();
      stage_enable = 4'b0001;
      stage_shift  = 20'h00002;
      send(16'sd3, pick(16'sd0, 16'sd1));
      drain();
      check("overrun_final", overrun, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
